fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and issues word requests to instruction memory over a req/rdy handshake.
- Delivers instrD and pcPlus4D to the decode-stage control unit.
- Honours decode-stage stall and branch-redirect (flush) requests.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000, instruction value driven on instrD during bubbles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- imemReqF  output  1  instruction memory request, registered
- imemAddrF  output  32  word-aligned fetch address, registered
- imemRdyF  input  1  memory has valid data on imemDataF this cycle
- imemDataF  input  32  fetched instruction word
- stallD  input  1  decode stage cannot accept a new instruction; hold IF/ID
- flushD  input  1  branch taken in decode; redirect fetch to branchTargetD
- branchTargetD  input  32  redirect address; bits [1:0] are ignored and forced to 0
- instrD  output  32  IF/ID instruction
- pcPlus4D  output  32  IF/ID PC+4 of instrD
- validD  output  1  instrD holds a real instruction (0 = bubble)

Behaviour:
- Reset is asynchronous, active-high, on reset.
- Reset values:
  - pcF = RESET_PC
  - imemReqF = 0, imemAddrF = RESET_PC
  - instrD = NOP_INSTR, pcPlus4D = 0, validD = 0
  - hold buffer empty, state = IDLE
- States:
  - IDLE: entered from reset. Next cycle → FETCH, with imemReqF=1 and imemAddrF=pcF.
  - FETCH: imemReqF=1.
  - HOLD: imemReqF=0, hold buffer full.
  - DRAIN: imemReqF=1 on the stale address; the response will be discarded.
- Handshake: while imemReqF=1, imemAddrF is stable until imemRdyF is sampled 1. imemRdyF is ignored when imemReqF=0. Zero-wait memory (rdy in the first req cycle) gives 1 instruction/cycle.
- FETCH, rdy=1, stallD=0:
  - instrD ← imemDataF, pcPlus4D ← pcF+4, validD ← 1
  - pcF ← pcF+4; next request issued back-to-back at the new address
- FETCH, rdy=1, stallD=1:
  - data and pcF+4 captured into the hold buffer; pcF ← pcF+4
  - imemReqF ← 0; → HOLD
  - IF/ID unchanged
- FETCH, rdy=0:
  - stallD=1: IF/ID holds.
  - stallD=0: validD ← 0, instrD ← NOP_INSTR (bubble); pcPlus4D holds.
- HOLD:
  - stallD=1: everything holds.
  - stallD=0: IF/ID ← buffer, validD ← 1, buffer emptied, imemReqF ← 1 at pcF; → FETCH.
- Flush (flushD=1): highest priority after reset, and overrides stallD.
  - pcF ← {branchTargetD[31:2],2'b00}
  - validD ← 0, instrD ← NOP_INSTR; hold buffer discarded
  - From FETCH with rdy=1, or from HOLD or IDLE: next state FETCH at the target address.
  - From FETCH with rdy=0: → DRAIN.
- DRAIN: keep the old request until rdy=1; discard its data; then issue the request at pcF; → FETCH.
- A second flush during DRAIN updates pcF and stays in DRAIN.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. No exception is raised.
- Reset mid-transaction abandons the outstanding request immediately (imemReqF drops asynchronously). Memory must tolerate this.
- Latency: an instruction appears on instrD 1 cycle after the edge at which rdy is sampled, with no stall.

Test Plan:
- Reset release with RESET_PC=0, zero-wait memory returning word=addr → imemAddrF sequence 0,4,8,C. instrD equals 0,4,8 on consecutive cycles starting 2 cycles after reset release; pcPlus4D=4,8,C; validD=1.
- 2-wait-state memory → imemAddrF stable for 3 cycles per word; validD pulses 1 once every 3 cycles; instrD=NOP_INSTR in between.
- stallD high for 3 cycles while rdy returns addr 8 → state HOLD, imemReqF=0, instrD stays at the addr-4 word. On stallD release, instrD=word@8, pcPlus4D=C, then fetch resumes at C.
- flushD with branchTargetD=32'h103 during a wait state → DRAIN. Stale data discarded, never appears on instrD. Next request address = 32'h100; validD=0 until word@100 arrives.
- flushD and stallD both high, with a word in the hold buffer → buffer discarded, validD=0, next fetch at target.
- PC at 32'hFFFF_FFFC fetched → pcPlus4D=0, next imemAddrF=0. Reset asserted mid-wait → imemReqF=0 and validD=0 immediately (asynchronously), pcF=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of a 5-stage MIPS
//   pipeline. Owns the PC, issues word requests to instruction memory over a
//   req/rdy handshake, and presents the fetched word to decode.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   imemReqF          registered request to instruction memory
//   imemAddrF         registered word-aligned fetch address
//   imemRdyF          memory presents valid data on imemDataF this cycle
//   imemDataF         fetched instruction word
//   stallD            decode cannot accept a new instruction; hold IF/ID
//   flushD            branch taken in decode; redirect fetch
//   branchTargetD     redirect address (bits [1:0] forced to 0)
//   instrD, pcPlus4D  IF/ID instruction and its PC+4
//   validD            instrD holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReqF,
  output logic [31:0] imemAddrF,
  input  logic        imemRdyF,
  input  logic [31:0] imemDataF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] branchTargetD,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;  // hold buffer is full exactly in this state
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;

  // 32-bit modulo increment: 0xFFFF_FFFC wraps to 0.
  assign pc_inc = pc_f + 32'd4;
  assign target = branchTargetD & ~32'd3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_f       <= RESET_PC;
      imemReqF   <= 1'b0;
      imemAddrF  <= RESET_PC;
      instrD     <= NOP_INSTR;
      pcPlus4D   <= '0;
      validD     <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc4   <= '0;
    end else if (flushD) begin
      // Redirect wins over stall; any buffered word is dropped by leaving HOLD.
      pc_f   <= target;
      validD <= 1'b0;
      instrD <= NOP_INSTR;
      if (imemReqF && !imemRdyF) begin
        // A request is in flight and its address must stay stable until it
        // completes; its data is thrown away in DRAIN.
        state <= S_DRAIN;
      end else begin
        state     <= S_FETCH;
        imemReqF  <= 1'b1;
        imemAddrF <= target;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          imemReqF  <= 1'b1;
          imemAddrF <= pc_f;
        end
        S_FETCH: begin
          if (imemRdyF) begin
            pc_f <= pc_inc;
            if (stallD) begin
              // Decode is busy: park the word and stop requesting.
              hold_instr <= imemDataF;
              hold_pc4   <= pc_inc;
              imemReqF   <= 1'b0;
              state      <= S_HOLD;
            end else begin
              instrD    <= imemDataF;
              pcPlus4D  <= pc_inc;
              validD    <= 1'b1;
              imemAddrF <= pc_inc;
            end
          end else if (!stallD) begin
            // Waiting on memory: push a bubble, pcPlus4D keeps its value.
            validD <= 1'b0;
            instrD <= NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!stallD) begin
            instrD    <= hold_instr;
            pcPlus4D  <= hold_pc4;
            validD    <= 1'b1;
            imemReqF  <= 1'b1;
            imemAddrF <= pc_f;
            state     <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Stale response consumed and discarded; now fetch the redirect.
          if (imemRdyF) begin
            imemAddrF <= pc_f;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
